// File: rtl/i2c_master_xfer_ctl.sv
// ============================================================================
// Module   : i2c_master_xfer_ctl
// Brief    : Word-level I2C master sequencer driving an external bit controller
//            (START/RESTART, DATA_W-bit read or write, ACK phase, STOP).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_master_xfer_ctl #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_start,
    input  logic              cmd_read,
    input  logic              cmd_write,
    input  logic              cmd_stop,
    input  logic              cmd_ack_n,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_ack,
    output logic              rsp_al,
    output logic              bus_owned,
    output logic [2:0]        bit_cmd,
    output logic              bit_din,
    input  logic              bit_done,
    input  logic              bit_dout,
    input  logic              bit_al
);

    localparam int                 c_CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(DATA_W - 1);

    localparam logic [2:0] c_BC_IDLE    = 3'd0;
    localparam logic [2:0] c_BC_START   = 3'd1;
    localparam logic [2:0] c_BC_WRITE   = 3'd2;
    localparam logic [2:0] c_BC_READ    = 3'd3;
    localparam logic [2:0] c_BC_RESTART = 3'd4;
    localparam logic [2:0] c_BC_STOP    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_read;
    logic                r_write;
    logic                r_stop;
    logic                r_ack_n;
    logic [DATA_W-1:0]   r_shift;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_bus_owned;
    logic                r_ack_res;
    logic                r_al_res;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_ack;
    logic                r_rsp_al;

    logic w_clr;
    logic w_accept;
    logic w_wr_cmd;
    logic w_tx_bit;
    logic w_rx_bit;

    assign w_clr    = reset | ~enable;
    assign w_accept = cmd_valid & cmd_ready;
    // Read takes precedence when both data directions are requested.
    assign w_wr_cmd = cmd_write & ~cmd_read;
    assign w_tx_bit = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];
    assign w_rx_bit = r_read & bit_dout;

    assign cmd_ready = (r_state == S_IDLE) & enable & ~reset & ~r_rsp_valid;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_ack   = r_rsp_ack;
    assign rsp_al    = r_rsp_al;
    assign bus_owned = r_bus_owned;

    always_ff @(posedge sysclk) begin
        if (w_clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        bit_cmd = c_BC_IDLE;
        bit_din = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_start)                  w_next = S_START;
                    else if (cmd_read || w_wr_cmd)  w_next = S_DATA;
                    else if (cmd_stop)              w_next = S_STOP;
                    else                            w_next = S_DONE;
                end
            end
            S_START: begin
                bit_cmd = r_bus_owned ? c_BC_RESTART : c_BC_START;
                if (bit_al)                         w_next = S_DONE;
                else if (bit_done) begin
                    if (r_read || r_write)          w_next = S_DATA;
                    else if (r_stop)                w_next = S_STOP;
                    else                            w_next = S_DONE;
                end
            end
            S_DATA: begin
                bit_cmd = r_read ? c_BC_READ : c_BC_WRITE;
                bit_din = r_read ? 1'b0 : w_tx_bit;
                if (bit_al)                         w_next = S_DONE;
                else if (bit_done && r_cnt == '0)   w_next = S_ACK;
            end
            S_ACK: begin
                bit_cmd = r_read ? c_BC_WRITE : c_BC_READ;
                bit_din = r_read ? r_ack_n : 1'b0;
                if (bit_al)                         w_next = S_DONE;
                else if (bit_done)                  w_next = r_stop ? S_STOP : S_DONE;
            end
            S_STOP: begin
                bit_cmd = c_BC_STOP;
                if (bit_al || bit_done)             w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (w_clr) begin
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_stop      <= 1'b0;
            r_ack_n     <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_bus_owned <= 1'b0;
            r_ack_res   <= 1'b1;
            r_al_res    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_ack   <= 1'b1;
            r_rsp_al    <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_read    <= cmd_read;
                        r_write   <= w_wr_cmd;
                        r_stop    <= cmd_stop;
                        r_ack_n   <= cmd_ack_n;
                        r_shift   <= w_wr_cmd ? cmd_data : '0;
                        r_cnt     <= c_CNT_LOAD;
                        r_ack_res <= 1'b1;
                        r_al_res  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= r_read ? r_shift : '0;
                    r_rsp_ack   <= r_ack_res;
                    r_rsp_al    <= r_al_res;
                end
                default: begin
                    // Arbitration loss overrides any coincident completion.
                    if (bit_al) begin
                        r_bus_owned <= 1'b0;
                        r_al_res    <= 1'b1;
                    end else if (bit_done) begin
                        case (r_state)
                            S_START: r_bus_owned <= 1'b1;
                            S_DATA: begin
                                r_cnt <= r_cnt - c_CNT_W'(1);
                                if (MSB_FIRST) begin
                                    r_shift <= (r_shift << 1) | DATA_W'(w_rx_bit);
                                end else begin
                                    r_shift <= (r_shift >> 1) | (DATA_W'(w_rx_bit) << (DATA_W - 1));
                                end
                            end
                            S_ACK: begin
                                if (r_write) r_ack_res <= bit_dout;
                            end
                            S_STOP: r_bus_owned <= 1'b0;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_xfer_ctl.sv
// ============================================================================
// Module   : tb_i2c_master_xfer_ctl
// Brief    : Scoreboard bench for i2c_master_xfer_ctl with a bit-ctl responder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2c_master_xfer_ctl;

    localparam logic [2:0] BC_IDLE = 3'd0, BC_START = 3'd1, BC_WRITE = 3'd2;
    localparam logic [2:0] BC_READ = 3'd3, BC_RESTART = 3'd4, BC_STOP = 3'd5;

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic       reset, enable;
    logic       cmd_valid, cmd_ready, cmd_start, cmd_read, cmd_write, cmd_stop, cmd_ack_n;
    logic [7:0] cmd_data, rsp_data;
    logic       rsp_valid, rsp_ack, rsp_al, bus_owned;
    logic [2:0] bit_cmd;
    logic       bit_din, bit_done, bit_dout, bit_al;

    logic        u_cmd_valid, u_cmd_ready, u_cmd_start, u_cmd_read, u_cmd_write, u_cmd_stop;
    logic [15:0] u_cmd_data, u_rsp_data;
    logic        u_rsp_valid, u_rsp_ack, u_rsp_al, u_bus_owned;
    logic [2:0]  u_bit_cmd;
    logic        u_bit_din, u_bit_done, u_bit_dout;

    i2c_master_xfer_ctl #(.DATA_W(8), .MSB_FIRST(1'b1)) u_dut (
        .sysclk(sysclk), .reset(reset), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start),
        .cmd_read(cmd_read), .cmd_write(cmd_write), .cmd_stop(cmd_stop),
        .cmd_ack_n(cmd_ack_n), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ack(rsp_ack), .rsp_al(rsp_al),
        .bus_owned(bus_owned), .bit_cmd(bit_cmd), .bit_din(bit_din),
        .bit_done(bit_done), .bit_dout(bit_dout), .bit_al(bit_al)
    );

    i2c_master_xfer_ctl #(.DATA_W(16), .MSB_FIRST(1'b0)) u_dut16 (
        .sysclk(sysclk), .reset(reset), .enable(enable),
        .cmd_valid(u_cmd_valid), .cmd_ready(u_cmd_ready), .cmd_start(u_cmd_start),
        .cmd_read(u_cmd_read), .cmd_write(u_cmd_write), .cmd_stop(u_cmd_stop),
        .cmd_ack_n(1'b0), .cmd_data(u_cmd_data),
        .rsp_valid(u_rsp_valid), .rsp_data(u_rsp_data), .rsp_ack(u_rsp_ack), .rsp_al(u_rsp_al),
        .bus_owned(u_bus_owned), .bit_cmd(u_bit_cmd), .bit_din(u_bit_din),
        .bit_done(u_bit_done), .bit_dout(u_bit_dout), .bit_al(1'b0)
    );

    typedef struct packed { logic [2:0] cmd; logic din; logic ck; } ebit_t;
    typedef struct packed { logic [7:0] data; logic ack; logic al; logic owned; logic timed; } ersp_t;

    ebit_t q_bits[$];
    ersp_t q_rsp[$];
    logic  q_dout[$];

    int n_vec = 0, n_err = 0, cyc = 0, last_ev = 0, rsp_cnt = 0, rsp_exp = 0, wait_cnt = 0;
    bit mon_on = 1'b1;
    bit m_owned = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic ebit_t mk(input logic [2:0] c, input logic dn, input logic ck);
        ebit_t e;
        e.cmd = c; e.din = dn; e.ck = ck;
        return e;
    endfunction

    // Bit-level controller stand-in: random completion delay, read data from q_dout.
    initial begin
        bit_done = 1'b0; bit_dout = 1'b0;
        forever begin
            @(posedge sysclk); #1;
            if (bit_done) bit_done = 1'b0;
            else if (bit_cmd != BC_IDLE) begin
                if (wait_cnt > 0) wait_cnt--;
                else begin
                    bit_done = 1'b1;
                    if (bit_cmd == BC_READ && q_dout.size() > 0) bit_dout = q_dout.pop_front();
                    else bit_dout = 1'($urandom);
                    wait_cnt = $urandom_range(0, 2);
                end
            end
        end
    end

    initial begin
        u_bit_done = 1'b0; u_bit_dout = 1'b0;
        forever begin
            @(posedge sysclk); #1;
            if (u_bit_done) u_bit_done = 1'b0;
            else if (u_bit_cmd != BC_IDLE) u_bit_done = 1'b1;
        end
    end

    // Monitor: completed bits and responses against the scoreboard queues.
    always @(negedge sysclk) begin
        cyc++;
        if (mon_on && bit_done && !bit_al && bit_cmd != BC_IDLE) begin
            last_ev = cyc;
            if (q_bits.size() == 0) chk("unexpected_bit", {29'd0, bit_cmd}, 32'd0);
            else begin
                ebit_t e;
                e = q_bits.pop_front();
                chk("bit_cmd", bit_cmd, e.cmd);
                if (e.ck) chk("bit_din", bit_din, e.din);
            end
        end
        if (bit_al && bit_cmd != BC_IDLE) last_ev = cyc;
        if (rsp_valid) begin
            rsp_cnt++;
            if (q_rsp.size() == 0) chk("unexpected_rsp", rsp_valid, 1'b0);
            else begin
                ersp_t r;
                r = q_rsp.pop_front();
                chk("rsp_data", rsp_data, r.data);
                chk("rsp_ack", rsp_ack, r.ack);
                chk("rsp_al", rsp_al, r.al);
                chk("bus_owned", bus_owned, r.owned);
                chk("ready_during_rsp", cmd_ready, 1'b0);
                if (r.timed) chk("rsp_latency", cyc - last_ev, 2);
            end
        end
    end

    task automatic wait_rsp();
        bit got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(posedge sysclk);
            got = (rsp_cnt >= rsp_exp);
        end
        chk("rsp_arrived", got, 1'b1);
    endtask

    task automatic handshake(input bit s, r, w, p, an, input logic [7:0] d, input bit busy);
        bit ok = 1'b0, rdy;
        @(posedge sysclk); #1;
        cmd_valid = 1'b1; cmd_start = s; cmd_read = r; cmd_write = w;
        cmd_stop = p; cmd_ack_n = an; cmd_data = d;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge sysclk); rdy = cmd_ready;
            @(posedge sysclk); ok = rdy;
        end
        #1;
        cmd_valid = 1'b0; cmd_start = 1'b0; cmd_read = 1'b0; cmd_write = 1'b0; cmd_stop = 1'b0;
        chk("accepted", ok, 1'b1);
        chk("ready_after_accept", cmd_ready, 1'b0);
        chk("first_bit_active", bit_cmd != BC_IDLE, busy);
    endtask

    // Reference model: expands one command into its bit sequence and response.
    task automatic send(input bit s, r, w, p, an, input logic [7:0] d, rd, input bit sa, input bit wt);
        bit rdx, wrx;
        ersp_t er;
        rdx = r; wrx = w & ~r;
        if (s) begin q_bits.push_back(mk(m_owned ? BC_RESTART : BC_START, 1'b0, 1'b0)); m_owned = 1'b1; end
        if (rdx) begin
            for (int i = 7; i >= 0; i--) begin q_bits.push_back(mk(BC_READ, 1'b0, 1'b0)); q_dout.push_back(rd[i]); end
            q_bits.push_back(mk(BC_WRITE, an, 1'b1));
        end else if (wrx) begin
            for (int i = 7; i >= 0; i--) q_bits.push_back(mk(BC_WRITE, d[i], 1'b1));
            q_bits.push_back(mk(BC_READ, 1'b0, 1'b0));
            q_dout.push_back(sa);
        end
        if (p) begin q_bits.push_back(mk(BC_STOP, 1'b0, 1'b0)); m_owned = 1'b0; end
        er.data = rdx ? rd : 8'h00; er.ack = wrx ? sa : 1'b1; er.al = 1'b0;
        er.owned = m_owned; er.timed = s | rdx | wrx | p;
        q_rsp.push_back(er); rsp_exp++;
        handshake(s, r, w, p, an, d, s | rdx | wrx | p);
        if (wt) wait_rsp();
    endtask

    task automatic run16(input logic [15:0] d);
        logic q16[$];
        bit got = 1'b0, ack = 1'b1;
        @(negedge sysclk); chk("w16_ready", u_cmd_ready, 1'b1);
        @(posedge sysclk); #1;
        u_cmd_valid = 1'b1; u_cmd_start = 1'b1; u_cmd_write = 1'b1; u_cmd_stop = 1'b1; u_cmd_data = d;
        @(posedge sysclk); #1;
        u_cmd_valid = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge sysclk);
            if (u_bit_done && u_bit_cmd == BC_WRITE) q16.push_back(u_bit_din);
            if (u_rsp_valid) begin got = 1'b1; ack = u_rsp_ack; end
        end
        chk("w16_rsp", got, 1'b1);
        chk("w16_nbits", q16.size(), 16);
        for (int i = 0; i < 16; i++) if (i < q16.size()) chk("w16_din", q16[i], d[i]);
        chk("w16_ack", ack, 1'b0);
        chk("w16_owned", u_bus_owned, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, rd;
        int s0, held;
        reset = 1'b1; enable = 1'b1; bit_al = 1'b0;
        cmd_valid = 1'b0; cmd_start = 1'b0; cmd_read = 1'b0; cmd_write = 1'b0;
        cmd_stop = 1'b0; cmd_ack_n = 1'b0; cmd_data = 8'h00;
        u_cmd_valid = 1'b0; u_cmd_start = 1'b0; u_cmd_read = 1'b0; u_cmd_write = 1'b0;
        u_cmd_stop = 1'b0; u_cmd_data = 16'h0;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rsp_ack", rsp_ack, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_al", rsp_al, 1'b0);
        chk("rst_bus_owned", bus_owned, 1'b0);
        chk("rst_bit_cmd", bit_cmd, BC_IDLE);
        @(posedge sysclk); #1; reset = 1'b0;

        send(1, 0, 1, 0, 0, 8'hA5, 8'h00, 0, 1);
        chk("owned_after_start", bus_owned, 1'b1);
        send(1, 1, 0, 1, 1, 8'h00, 8'h3C, 0, 1);
        chk("owned_after_stop", bus_owned, 1'b0);

        send(0, 0, 0, 0, 0, 8'h5A, 8'h00, 0, 0);
        @(negedge sysclk); chk("empty_rsp_t1", rsp_valid, 1'b0);
        @(negedge sysclk); chk("empty_rsp_t2", rsp_valid, 1'b1);
        wait_rsp();
        @(negedge sysclk); chk("empty_ready_after", cmd_ready, 1'b1);

        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom); rd = 8'($urandom);
            send(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 d, rd, 1'($urandom), 1);
        end

        // Arbitration loss in the 4th write bit.
        d = 8'($urandom);
        q_bits.push_back(mk(m_owned ? BC_RESTART : BC_START, 1'b0, 1'b0));
        for (int i = 7; i >= 5; i--) q_bits.push_back(mk(BC_WRITE, d[i], 1'b1));
        m_owned = 1'b0;
        q_rsp.push_back(ersp_t'({8'h00, 1'b1, 1'b1, 1'b0, 1'b1}));
        rsp_exp++;
        handshake(1, 0, 1, 1, 0, d, 1);
        for (int k = 0; k < 200 && q_bits.size() != 0; k++) begin @(posedge sysclk); #1; end
        bit_al = 1'b1;
        @(posedge sysclk); #1; bit_al = 1'b0;
        @(negedge sysclk);
        chk("al_bit_cmd_idle", bit_cmd, BC_IDLE);
        chk("al_bus_released", bus_owned, 1'b0);
        wait_rsp();
        @(negedge sysclk); chk("al_ready_after", cmd_ready, 1'b1);

        // Enable dropped mid-read, then restored.
        send(1, 1, 0, 1, 0, 8'h00, 8'($urandom), 0, 0);
        s0 = q_bits.size();
        for (int k = 0; k < 200 && q_bits.size() > s0 - 4; k++) begin @(posedge sysclk); #1; end
        mon_on = 1'b0; enable = 1'b0;
        @(negedge sysclk); @(negedge sysclk);
        chk("en_bit_cmd", bit_cmd, BC_IDLE);
        chk("en_bus_owned", bus_owned, 1'b0);
        chk("en_cmd_ready", cmd_ready, 1'b0);
        chk("en_rsp_ack", rsp_ack, 1'b1);
        chk("en_rsp_al", rsp_al, 1'b0);
        chk("en_rsp_data", rsp_data, 8'h00);
        q_bits.delete(); q_rsp.delete(); q_dout.delete();
        rsp_exp--; m_owned = 1'b0;
        held = rsp_cnt;
        @(posedge sysclk); #1; enable = 1'b1; mon_on = 1'b1;
        repeat (10) @(posedge sysclk);
        chk("en_no_rsp", rsp_cnt, held);
        send(1, 0, 1, 1, 0, 8'($urandom), 8'h00, 1'($urandom), 1);

        run16(16'h8001);
        run16(16'($urandom));

        repeat (3) @(posedge sysclk);
        chk("scoreboard_drained", q_rsp.size() + q_bits.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
